// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution operand feeder.
// No logic; imported by conv_feeder and conv_buf.
package conv_pkg;

    localparam int WIDTH_DEF = 14;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_F,
        LOAD_X,
        CLEAR,
        MAC,
        DRAIN,
        DONE
    } state_t;

    // Address width for an n-entry array; never below one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int idx_w(input int n, input int m);
        return addr_w(n - m + 1);
    endfunction

endpackage

// File: rtl/conv_buf.sv
// Sample (x) and coefficient (f) storage: one write port, two async read ports.
// Writes land on the next edge; reads are combinational. No backpressure.
// Contents are intentionally not reset; every job reloads them.
module conv_buf import conv_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N     = 8,
    parameter int M     = 4
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic                    wr_sel_x,
    input  logic [addr_w(N)-1:0]    wr_addr,
    input  logic signed [WIDTH-1:0] wr_dat,
    input  logic [addr_w(N)-1:0]    x_raddr,
    output logic signed [WIDTH-1:0] x_rdat,
    input  logic [addr_w(M)-1:0]    f_raddr,
    output logic signed [WIDTH-1:0] f_rdat
);
    localparam int FW = addr_w(M);

    logic signed [WIDTH-1:0] x_q [N];
    logic signed [WIDTH-1:0] f_q [M];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_sel_x) begin
                x_q[wr_addr] <= wr_dat;
            end else begin
                f_q[wr_addr[FW-1:0]] <= wr_dat;
            end
        end
    end

    assign x_rdat = x_q[x_raddr];
    assign f_rdat = f_q[f_raddr];

endmodule

// File: rtl/conv_feeder.sv
// Loads M taps and N samples, then streams (x[i+j], f[j]) pairs to a MAC per output.
// All outputs registered; period per output is 1 + M + DRAIN_CYC cycles.
// Load side stalls on s_valid gaps via s_ready; MAC side has no backpressure.
module conv_feeder import conv_pkg::*; #(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int N         = 8,
    parameter int M         = 4,
    parameter int DRAIN_CYC = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic signed [WIDTH-1:0] a_out,
    output logic signed [WIDTH-1:0] b_out,
    output logic                    mac_valid,
    output logic                    mac_clear,
    output logic                    last_tap,
    output logic [idx_w(N, M)-1:0]  out_idx,
    output logic                    busy,
    output logic                    done
);
    localparam int OW    = idx_w(N, M);
    localparam int XW    = addr_w(N);
    localparam int FW    = addr_w(M);
    localparam int CNT_W = addr_w(N + DRAIN_CYC + 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OW-1:0]           out_idx_q, out_idx_d;
    logic                    s_ready_q, s_ready_d;
    logic                    mac_valid_q, mac_valid_d;
    logic                    mac_clear_q, mac_clear_d;
    logic                    last_tap_q, last_tap_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic signed [WIDTH-1:0] a_out_q, a_out_d;
    logic signed [WIDTH-1:0] b_out_q, b_out_d;

    logic                    xfer;
    logic                    wr_en;
    logic [XW-1:0]           x_raddr;
    logic [FW-1:0]           f_raddr;
    logic signed [WIDTH-1:0] x_rdat;
    logic signed [WIDTH-1:0] f_rdat;

    assign xfer = s_valid && s_ready_q;

    conv_buf #(.WIDTH(WIDTH), .N(N), .M(M)) u_buf (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_sel_x (state_q == LOAD_X),
        .wr_addr  (XW'(cnt_q)),
        .wr_dat   (s_data),
        .x_raddr  (x_raddr),
        .x_rdat   (x_rdat),
        .f_raddr  (f_raddr),
        .f_rdat   (f_rdat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_idx_q   <= '0;
            s_ready_q   <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_clear_q <= 1'b0;
            last_tap_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_idx_q   <= out_idx_d;
            s_ready_q   <= s_ready_d;
            mac_valid_q <= mac_valid_d;
            mac_clear_q <= mac_clear_d;
            last_tap_q  <= last_tap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
        end
    end

    // cnt_q is shared: load address, tap index, then drain countdown.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_idx_d = out_idx_q;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_F;
                    cnt_d   = '0;
                end
            end
            LOAD_F: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (cnt_q == CNT_W'(M - 1)) begin
                        state_d = LOAD_X;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD_X: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CLEAR: begin
                state_d = MAC;
                cnt_d   = '0;
            end
            MAC: begin
                if (cnt_q == CNT_W'(M - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
                    cnt_d = '0;
                    if (out_idx_q < OW'(N - M)) begin
                        state_d   = CLEAR;
                        out_idx_d = out_idx_q + OW'(1);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d   = IDLE;
                out_idx_d = '0;
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                out_idx_d = '0;
            end
        endcase
    end

    // Outputs decode the next state so they line up with state_q after the edge.
    assign x_raddr = XW'(out_idx_d) + XW'(cnt_d);
    assign f_raddr = FW'(cnt_d);

    always_comb begin
        s_ready_d   = (state_d == LOAD_F) || (state_d == LOAD_X);
        mac_clear_d = (state_d == CLEAR);
        mac_valid_d = (state_d == MAC);
        last_tap_d  = (state_d == MAC) && (cnt_d == CNT_W'(M - 1));
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        a_out_d     = '0;
        b_out_d     = '0;
        if (state_d == MAC) begin
            a_out_d = x_rdat;
            b_out_d = f_rdat;
        end
    end

    assign s_ready   = s_ready_q;
    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign mac_valid = mac_valid_q;
    assign mac_clear = mac_clear_q;
    assign last_tap  = last_tap_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_feeder.sv
// Directed job vectors for conv_feeder: operand order, MAC sums, timing, reset.
module tb_conv_feeder;

    typedef struct packed {
        logic              gaps;
        logic              inj;
        logic [3:0][13:0]  f;
        logic [7:0][13:0]  x;
        logic [4:0][31:0]  e;
    } vec_t;

    localparam int NV = 5;

    logic               clk;
    logic               reset;
    logic               start;
    logic signed [13:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic signed [13:0] a_out;
    logic signed [13:0] b_out;
    logic               mac_valid;
    logic               mac_clear;
    logic               last_tap;
    logic [2:0]         out_idx;
    logic               busy;
    logic               done;

    int checks   = 0;
    int failures = 0;

    vec_t vecs [NV];

    conv_feeder #(.WIDTH(14), .N(8), .M(4), .DRAIN_CYC(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .mac_valid (mac_valid),
        .mac_clear (mac_clear),
        .last_tap  (last_tap),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic g, input logic inj,
                                input int f[4], input int x[8], input int e[5]);
        vec_t v;
        v = '0;
        v.gaps = g;
        v.inj  = inj;
        for (int i = 0; i < 4; i++) v.f[i] = 14'(f[i]);
        for (int i = 0; i < 8; i++) v.x[i] = 14'(x[i]);
        for (int i = 0; i < 5; i++) v.e[i] = 32'(e[i]);
        return v;
    endfunction

    task automatic chk_all_zero(input string nm);
        chk({nm, "_s_ready"}, s_ready, 0);
        chk({nm, "_mac_valid"}, mac_valid, 0);
        chk({nm, "_mac_clear"}, mac_clear, 0);
        chk({nm, "_last_tap"}, last_tap, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_a_out"}, a_out, 0);
        chk({nm, "_b_out"}, b_out, 0);
        chk({nm, "_out_idx"}, out_idx, 0);
    endtask

    // Starts a job, loads f then x, and follows it to done. abort_c >= 0
    // returns early that many cycles after the first clear.
    task automatic run_job(input vec_t v, input int abort_c);
        logic [11:0][13:0] w;
        int  idx, cyc, c, k, j, nclr, ntap, sum;
        logic hs, prev_clear, got_done;
        for (int i = 0; i < 4; i++) w[i] = v.f[i];
        for (int i = 0; i < 8; i++) w[4 + i] = v.x[i];

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("s_ready_in_load", s_ready, 1);

        idx = 0;
        cyc = 0;
        while (idx < 12 && cyc < 100) begin
            s_valid = !(v.gaps && (cyc % 2 == 1));
            s_data  = w[idx];
            hs      = s_valid && s_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
            if (idx < 12) chk("no_early_clear", mac_clear, 0);
        end
        s_valid = 1'b0;
        chk("load_words", idx, 12);
        chk("load_cycles", cyc, v.gaps ? 23 : 12);
        chk("clear_after_load", mac_clear, 1);
        chk("s_ready_after_load", s_ready, 0);

        c = 0; k = 0; j = 0; nclr = 0; ntap = 0; sum = 0;
        prev_clear = 1'b0;
        got_done   = 1'b0;
        while (!got_done && c < 100) begin
            if (c == abort_c) begin
                start = 1'b0;
                return;
            end
            start = v.inj && (c == 2);
            if (mac_clear) begin
                chk("clear_no_valid", mac_valid, 0);
                k = nclr;
                nclr++;
                j = 0;
                sum = 0;
                chk("clear_period", c, 8 * k);
            end
            if (mac_valid) begin
                if (j == 0) chk("clear_precedes", prev_clear, 1);
                if (j < 4 && k + j < 8) begin
                    chk("a_out", a_out, $signed(v.x[k + j]));
                    chk("b_out", b_out, $signed(v.f[j]));
                    chk("last_tap", last_tap, (j == 3) ? 1 : 0);
                    chk("out_idx", out_idx, k);
                    sum += int'(a_out) * int'(b_out);
                    if (j == 3) chk("mac_sum", sum, $signed(v.e[k]));
                end else begin
                    chk("extra_tap", j, 3);
                end
                j++;
                ntap++;
            end
            if (done) begin
                chk("done_cycle", c, 40);
                chk("num_outputs", nclr, 5);
                chk("num_taps", ntap, 20);
                got_done = 1'b1;
            end
            prev_clear = mac_clear;
            if (!got_done) begin
                @(posedge clk); #1;
                c++;
            end
        end
        start = 1'b0;
        chk("done_seen", got_done, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("done_single", done, 0);
            chk("idle_after_done", busy, 0);
            chk("out_idx_reset", out_idx, 0);
        end
    endtask

    initial begin
        int fa[4];
        int xa[8];
        int ea[5];

        fa = '{1, 1, 1, 1};
        xa = '{1, 2, 3, 4, 5, 6, 7, 8};
        ea = '{10, 14, 18, 22, 26};
        vecs[0] = mk(1'b0, 1'b0, fa, xa, ea);

        fa = '{1, 2, 3, 4};
        ea = '{30, 40, 50, 60, 70};
        vecs[1] = mk(1'b1, 1'b0, fa, xa, ea);

        fa = '{1, 1, 1, 1};
        xa = '{8, 7, 6, 5, 4, 3, 2, 1};
        ea = '{26, 22, 18, 14, 10};
        vecs[2] = mk(1'b0, 1'b1, fa, xa, ea);

        fa = '{-8192, 8191, -1, 0};
        xa = '{-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192};
        ea = '{16384, 16384, 16384, 16384, 16384};
        vecs[3] = mk(1'b0, 1'b0, fa, xa, ea);

        fa = '{0, 0, 0, 1};
        xa = '{-5, 3, 7, -1, 8191, -8192, 2, 0};
        ea = '{-1, 8191, -8192, 2, 0};
        vecs[4] = mk(1'b1, 1'b0, fa, xa, ea);

        reset   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_s_ready", s_ready, 0);

        for (int i = 0; i < NV; i++) begin
            run_job(vecs[i], -1);
        end

        // Asynchronous reset in the middle of the first output's taps.
        run_job(vecs[0], 3);
        chk("pre_reset_mac_valid", mac_valid, 1);
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("midjob_reset");
        @(posedge clk); #1;
        chk("reset_held_busy", busy, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        run_job(vecs[1], -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_feeder.md
CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 14, meaning operand width in bits (signed).
REQ-002 SHALL have parameter N, default 8, meaning input-sample vector length.
REQ-003 SHALL have parameter M, default 4, meaning filter tap count; N >= M.
REQ-004 SHALL have parameter DRAIN_CYC, default 3, meaning idle cycles after the last tap before the next clear.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1, meaning a request to begin a load/compute job.
REQ-008 SHALL have port s_data, input, WIDTH signed, meaning the load data word.
REQ-009 SHALL have port s_valid, input, 1, meaning s_data is valid.
REQ-010 SHALL have port s_ready, output, 1, meaning the block accepts s_data this cycle.
REQ-011 SHALL have ports a_out and b_out, output, WIDTH signed, meaning the MAC operands (sample and tap).
REQ-012 SHALL have port mac_valid, output, 1, meaning a_out/b_out are valid (drives MAC valid_in).
REQ-013 SHALL have port mac_clear, output, 1, meaning an active-high accumulator clear for the MAC.
REQ-014 SHALL have port last_tap, output, 1, meaning the current operand pair is the final tap of one output.
REQ-015 SHALL have port out_idx, output, clog2(N-M+1) bits, meaning the index of the output being computed.
REQ-016 SHALL have ports busy and done, output, 1 each; busy means not IDLE, done is a single-cycle job-complete pulse.

Function
REQ-017 SHALL implement states IDLE, LOAD_F, LOAD_X, CLEAR, MAC, DRAIN, DONE.
REQ-018 SHALL go from IDLE to LOAD_F when start=1; start SHALL be ignored in every other state.
REQ-019 SHALL assert s_ready only in LOAD_F/LOAD_X; a word transfers when s_valid&&s_ready.
REQ-020 SHALL store M transfers in LOAD_F as f[0..M-1], then go to LOAD_X; SHALL store N transfers as x[0..N-1], then go to CLEAR; s_valid gaps stall without loss.
REQ-021 SHALL hold mac_clear=1, mac_valid=0 for exactly one cycle in CLEAR, then enter MAC.
REQ-022 SHALL, in MAC, for tap j=0..M-1 on consecutive cycles, drive a_out=x[out_idx+j], b_out=f[j], mac_valid=1, with last_tap=1 at j=M-1 only.
REQ-023 SHALL register all outputs so that a_out, b_out, mac_valid and last_tap change together on the same edge.
REQ-024 SHALL stay DRAIN_CYC cycles in DRAIN with mac_valid=0; then go to CLEAR with out_idx+1 if out_idx<N-M, else go to DONE.
REQ-025 SHALL pulse done=1 for one cycle in DONE, then return to IDLE with out_idx=0.
REQ-026 SHALL pass operands bit-exact with no arithmetic; extremes -2^(WIDTH-1) and 2^(WIDTH-1)-1 are unchanged.
REQ-027 SHALL spend 1+M+DRAIN_CYC cycles per output and (N-M+1) such periods per job.

Reset
REQ-028 SHALL, on reset=0, immediately force state IDLE, out_idx=0, and all outputs 0 (s_ready, mac_valid, mac_clear, last_tap, busy, done, a_out, b_out), including mid-job.
REQ-029 SHALL leave the sample and coefficient storage uncleared by reset; a new job always reloads it.

Structure
REQ-030 SHALL take the state enum and default WIDTH constant from shared package conv_pkg.
REQ-031 SHALL place x/f storage in one sub-module, conv_buf (write port, two combinational read ports).

Verification
REQ-032 Bench SHALL cover: N=8, M=4, f={1,1,1,1}, x=1..8 -> 5 outputs; a/b sequences per REQ-022; downstream MAC sums 10,14,18,22,26; done 40 cycles after first CLEAR.
REQ-033 Bench SHALL cover: s_valid low on every other cycle during load -> 12 words captured in order; no duplicates; CLEAR entered only after the 12th transfer.
REQ-034 Bench SHALL cover: start pulsed during MAC -> ignored; the job completes unchanged with a single done pulse.
REQ-035 Bench SHALL cover: reset=0 asserted mid-MAC between edges -> outputs 0 immediately, busy=0; a new start with reload gives correct results.
REQ-036 Bench SHALL cover: f={-8192,8191,-1,0}, x all -8192 -> b_out exactly -8192, 8191, -1, 0 each output; mac_clear precedes each group by one cycle.
